multicycle_ctrl: RTL

Multi-cycle control FSM for the CPU core. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives `com_format` into the instruction decoder. It also arbitrates the single shared memory port between instruction fetch and data access, and generates all datapath strobes. It sits beside the decoder, register file, ALU and PC register, and consumes `opcode`/`funct` from the decoder output of the instruction register (IR).

---
 rtl/multicycle_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// arbitrates the shared memory port and drives all datapath strobes.
// Only the state and the retired-instruction counter are registered.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       com_format,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             wb_sel,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;

    logic       w_is_r, w_r_ok, w_addi, w_lw, w_sw, w_beq, w_j, w_halt, w_legal;
    logic [2:0] w_r_alu;
    logic       w_retire;

    assign w_is_r = (opcode == 6'b000000);
    assign w_addi = (opcode == 6'b001000);
    assign w_lw   = (opcode == 6'b100011);
    assign w_sw   = (opcode == 6'b101011);
    assign w_beq  = (opcode == 6'b000100);
    assign w_j    = (opcode == 6'b000010);
    assign w_halt = (opcode == 6'b111111);

    // R-type funct decode: ALU operation and whether the funct is supported
    always_comb begin
        w_r_ok  = 1'b1;
        w_r_alu = ALU_ADD;
        case (funct)
            6'b100000: w_r_alu = ALU_ADD;
            6'b100010: w_r_alu = ALU_SUB;
            6'b100100: w_r_alu = ALU_AND;
            6'b100101: w_r_alu = ALU_OR;
            6'b101010: w_r_alu = ALU_SLT;
            6'b000000: w_r_alu = ALU_SLL;
            default:   w_r_ok  = 1'b0;
        endcase
    end

    assign w_legal = (w_is_r & w_r_ok) | w_addi | w_lw | w_sw | w_beq | w_j | w_halt;

    // An instruction retires on the edge that leaves its last state
    assign w_retire = ((r_state == S_DECODE) & w_j)
                    | ((r_state == S_EXEC) & w_beq)
                    | ((r_state == S_MEM) & mem_ready & w_sw)
                    | (r_state == S_WB);

    // Instruction format hint to the decoder; only meaningful once IR holds it
    always_comb begin
        case (r_state)
            S_DECODE, S_EXEC, S_MEM, S_WB:
                com_format = w_is_r ? 2'b00 : (w_j ? 2'b10 : 2'b01);
            default:
                com_format = 2'b11;
        endcase
    end

    // Moore strobes from state, refined by opcode/funct/zero
    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = 2'b00;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_sel = 1'b0;
        reg_we  = 1'b0;
        reg_dst = 1'b0;
        wb_sel  = 1'b0;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        halted  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    illegal = 1'b1;
                end else if (w_j) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b10;
                end
            end
            S_EXEC: begin
                if (w_is_r) begin
                    alu_op = w_r_alu;
                end else if (w_addi | w_lw | w_sw) begin
                    alu_src = 1'b1;
                end else if (w_beq) begin
                    alu_op = ALU_SUB;
                    if (zero) begin
                        pc_we  = 1'b1;
                        pc_src = 2'b01;
                    end
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = w_sw;
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = w_is_r;
                wb_sel  = w_lw;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    // State sequencing and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
            case (r_state)
                S_IDLE:   if (run) r_state <= S_FETCH;
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_halt)                r_state <= S_HALT;
                    else if (!w_legal || w_j)  r_state <= S_FETCH;
                    else                       r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_lw || w_sw)          r_state <= S_MEM;
                    else if (w_beq)            r_state <= S_FETCH;
                    else                       r_state <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready)             r_state <= w_lw ? S_WB : S_FETCH;
                end
                S_WB:     r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_count = r_count;
    assign state       = r_state;

endmodule
